// File: rtl/ts_ctrl_pkg.sv
// Shared types and constants for the TurboSound (dual YM2149) controller.
package ts_ctrl_pkg;

  // Chip-select codes written to the register-select port.
  localparam logic [7:0] TS_SEL_CHIP0 = 8'hFF;
  localparam logic [7:0] TS_SEL_CHIP1 = 8'hFE;

  // One queued bus command; the chip is captured at enqueue time.
  typedef struct packed {
    logic       chip;
    logic       is_addr;
    logic [7:0] data;
  } ts_cmd_t;

  // Bus-cycle sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    RECOVER
  } ts_state_t;

  // True when a register-select value is one of the chip-select codes.
  function automatic logic is_chip_sel_code(input logic [7:0] d);
    return (d == TS_SEL_CHIP0) || (d == TS_SEL_CHIP1);
  endfunction

endpackage

// File: rtl/ts_cmd_fifo.sv
// Synchronous command FIFO for the TurboSound controller.
// A push while full is accepted only when a pop happens in the same cycle.
module ts_cmd_fifo
  import ts_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   push,
  input  logic                   pop,
  input  ts_cmd_t                din,
  output ts_cmd_t                dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  ts_cmd_t            mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage write.
  // NOTE: the storage array is deliberately not reset; only pointers and count
  // define validity, and leaving it reset-free lets it map onto plain RAM/regs.
  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/turbosound_ctrl.sv
// TurboSound controller: decodes CPU port writes, queues them, and replays
// each as a SETUP / STROBE / RECOVER bus cycle on one of two YM2149 chips.
module turbosound_ctrl
  import ts_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PULSE_LEN  = 2,
  parameter int TS_ENABLE  = 1
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       IO_WR,
  input  logic       IO_RD,
  input  logic       A_SEL,
  input  logic [7:0] D_IN,
  output logic [7:0] D_OUT,
  output logic       WAIT,
  output logic       BUSY,
  output logic       OVERFLOW,
  output logic       CHIP_SEL,
  output logic [7:0] PSG_DI,
  output logic       BDIR0,
  output logic       BC0,
  output logic       BDIR1,
  output logic       BC1,
  input  logic [7:0] PSG_DO0,
  input  logic [7:0] PSG_DO1
);

  localparam int               PTR_W      = $clog2(FIFO_DEPTH);
  localparam int               CNT_W      = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);

  ts_state_t          state;
  ts_cmd_t            cur_cmd;
  ts_cmd_t            push_cmd;
  ts_cmd_t            fifo_dout;
  logic [PTR_W:0]     fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic               sel_wr;
  logic               push_req;
  logic               chip_sel_q;
  logic               overflow_q;
  logic [CNT_W-1:0]   pulse_cnt;
  logic               bdir0_q, bc0_q, bdir1_q, bc1_q;

  // Reads have no side effects, so IO_RD only matters to the host.
  logic unused_rd;
  assign unused_rd = IO_RD;

  // Write decode: chip-select codes bypass the queue in two-chip mode.
  assign sel_wr   = IO_WR && !A_SEL && (TS_ENABLE != 0) && is_chip_sel_code(D_IN);
  assign push_req = IO_WR && !sel_wr;
  assign fifo_pop = (state == IDLE) && !fifo_empty;

  // Command assembled from the live chip select at enqueue time.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    push_cmd         = '0;
    push_cmd.chip    = chip_sel_q;
    push_cmd.is_addr = !A_SEL;
    push_cmd.data    = D_IN;
  end

  ts_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .push    (push_req),
    .pop     (fifo_pop),
    .din     (push_cmd),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Chip-select register and sticky overflow flag.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      chip_sel_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (sel_wr) chip_sel_q <= (D_IN == TS_SEL_CHIP1);
      if (push_req && fifo_full && !fifo_pop) overflow_q <= 1'b1;
    end
  end

  // Bus-cycle sequencer with registered BDIR/BC and data outputs.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state     <= IDLE;
      cur_cmd   <= '0;
      pulse_cnt <= '0;
      bdir0_q   <= 1'b0;
      bc0_q     <= 1'b0;
      bdir1_q   <= 1'b0;
      bc1_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            cur_cmd <= fifo_dout;
            state   <= SETUP;
          end
        end
        SETUP: begin
          pulse_cnt <= '0;
          bdir0_q   <= !cur_cmd.chip;
          bc0_q     <= !cur_cmd.chip && cur_cmd.is_addr;
          bdir1_q   <= cur_cmd.chip;
          bc1_q     <= cur_cmd.chip && cur_cmd.is_addr;
          state     <= STROBE;
        end
        STROBE: begin
          if (pulse_cnt == PULSE_LAST) begin
            bdir0_q <= 1'b0;
            bc0_q   <= 1'b0;
            bdir1_q <= 1'b0;
            bc1_q   <= 1'b0;
            state   <= RECOVER;
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign PSG_DI   = cur_cmd.data;
  assign BDIR0    = bdir0_q;
  assign BC0      = bc0_q;
  assign BDIR1    = (TS_ENABLE != 0) && bdir1_q;
  assign BC1      = (TS_ENABLE != 0) && bc1_q;
  assign CHIP_SEL = chip_sel_q;
  assign OVERFLOW = overflow_q;
  assign WAIT     = (fifo_count == (PTR_W + 1)'(FIFO_DEPTH));
  assign BUSY     = !fifo_empty || (state != IDLE);
  assign D_OUT    = A_SEL ? 8'hFF : (chip_sel_q ? PSG_DO1 : PSG_DO0);

endmodule
